// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between the ALU result path (2*WIDTH) and the register-file read path (WIDTH).
// Optional macro UART_TX_SCHED_MSB_FIRST_EN sends the ALU high byte first.
module uart_tx_sched #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [2*WIDTH-1:0] ALU_Out,
  input  logic               ALU_Valid,
  input  logic [WIDTH-1:0]   RdData,
  input  logic               RdData_Valid,
  input  logic               Tx_Busy,
  output logic [WIDTH-1:0]   Tx_Data,
  output logic               Tx_Data_Valid,
  output logic               Sched_Busy,
  output logic [1:0]         Overflow
);

`ifdef UART_TX_SCHED_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  localparam logic G_ALU = 1'b0;
  localparam logic G_RD  = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_e;

  state_e               state_q, state_d;
  logic                 pend_alu_q, pend_alu_d;
  logic                 pend_rd_q, pend_rd_d;
  logic [2*WIDTH-1:0]   hold_alu_q, hold_alu_d;
  logic [WIDTH-1:0]     hold_rd_q, hold_rd_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 idx_q, idx_d;
  logic [WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                 tx_vld_q, tx_vld_d;
  logic [1:0]           ovf_q, ovf_d;
  logic                 issue, last_byte, alu_free, rd_free;

  always_comb begin
    state_d    = state_q;
    pend_alu_d = pend_alu_q;
    pend_rd_d  = pend_rd_q;
    hold_alu_d = hold_alu_q;
    hold_rd_d  = hold_rd_q;
    grant_d    = grant_q;
    last_d     = last_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = 1'b0;
    ovf_d      = ovf_q;
    issue      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if ((pend_alu_q || pend_rd_q) && !Tx_Busy) begin
          if (pend_alu_q && pend_rd_q) grant_d = ~last_q;
          else                         grant_d = pend_alu_q ? G_ALU : G_RD;
          last_d  = grant_d;
          idx_d   = 1'b0;
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE:   state_d = WAIT_HI;
      WAIT_HI: if (Tx_Busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!Tx_Busy) begin
          if (grant_q == G_ALU && !idx_q) begin
            idx_d   = 1'b1;
            state_d = ISSUE;
            issue   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte is registered on entry to ISSUE so the strobe lines up with the state.
    if (issue) begin
      tx_vld_d = 1'b1;
      if (grant_d == G_RD)             tx_data_d = hold_rd_q;
      else if (idx_d ^ MSB_FIRST)      tx_data_d = hold_alu_q[2*WIDTH-1:WIDTH];
      else                             tx_data_d = hold_alu_q[WIDTH-1:0];
    end

    // A word frees its slot in the cycle its final byte is on the wire.
    last_byte = (state_q == ISSUE) && (grant_q == G_RD || idx_q);
    alu_free  = !pend_alu_q || (last_byte && grant_q == G_ALU);
    rd_free   = !pend_rd_q  || (last_byte && grant_q == G_RD);
    if (last_byte && grant_q == G_ALU) pend_alu_d = 1'b0;
    if (last_byte && grant_q == G_RD)  pend_rd_d  = 1'b0;

    if (ALU_Valid) begin
      if (alu_free) begin
        hold_alu_d = ALU_Out;
        pend_alu_d = 1'b1;
      end else begin
        ovf_d[0] = 1'b1;
      end
    end
    if (RdData_Valid) begin
      if (rd_free) begin
        hold_rd_d = RdData;
        pend_rd_d = 1'b1;
      end else begin
        ovf_d[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q    <= IDLE;
      pend_alu_q <= 1'b0;
      pend_rd_q  <= 1'b0;
      hold_alu_q <= '0;
      hold_rd_q  <= '0;
      grant_q    <= G_ALU;
      last_q     <= G_RD;
      idx_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      ovf_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      pend_alu_q <= pend_alu_d;
      pend_rd_q  <= pend_rd_d;
      hold_alu_q <= hold_alu_d;
      hold_rd_q  <= hold_rd_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Tx_Data       = tx_data_q;
  assign Tx_Data_Valid = tx_vld_q;
  assign Overflow      = ovf_q;
  assign Sched_Busy    = pend_alu_q || pend_rd_q || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: 11-cycle UART busy model, word-level scheduler model, directed and random traffic.
module tb_uart_tx_sched;
`ifdef UART_TX_SCHED_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_vld = 1'b0;
  logic [7:0]  rd = '0;
  logic        rd_vld = 1'b0;
  logic        tx_busy, tx_vld, sbusy;
  logic [7:0]  tx_data;
  logic [1:0]  ovf;
  int          busy_cnt = 0;

  uart_tx_sched #(.WIDTH(8)) dut (
    .CLK(clk), .Reset(rst_n), .ALU_Out(alu_out), .ALU_Valid(alu_vld),
    .RdData(rd), .RdData_Valid(rd_vld), .Tx_Busy(tx_busy),
    .Tx_Data(tx_data), .Tx_Data_Valid(tx_vld), .Sched_Busy(sbusy), .Overflow(ovf)
  );

  always #5 clk = ~clk;

  // UART transmitter: busy for 11 cycles after each accepted strobe
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_vld)             busy_cnt <= 11;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  int n_chk = 0, n_pass = 0, cyc = 0, first_pulse_cyc = -1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Word-level model: 0=ALU, 1=RdData
  bit          m_init = 0, m_rst_prev = 0, m_exp_pulse = 0, m_exp_sbusy = 0;
  bit          m_pend [2];
  logic [15:0] m_word [2];
  logic [1:0]  m_ovf = '0;
  logic [7:0]  m_last_data = '0;
  int          m_last = 1, m_cur = -1, m_sent = 0, m_hs = 0;
  logic [7:0]  log_q[$];

  always @(negedge clk) begin
    logic [7:0] exp_b;
    bit         fin, nxt;
    int         hs0, sel;
    cyc++;
    if (m_init) begin
      if (m_rst_prev) begin
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_vld, 0);
        chk("rst_sched_busy", sbusy, 0);
        chk("rst_overflow", ovf, 0);
      end else begin
        chk("pulse_timing", tx_vld, m_exp_pulse);
        chk("overflow", ovf, m_ovf);
        chk("sched_busy", sbusy, m_exp_sbusy);
        if (tx_vld) begin
          chk("pulse_while_busy", tx_busy, 0);
          if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
          log_q.push_back(tx_data);
          if (m_cur >= 0) begin
            if (m_cur == 1) exp_b = m_word[1][7:0];
            else if ((m_sent == 1) ^ MSB) exp_b = m_word[0][15:8];
            else exp_b = m_word[0][7:0];
            chk("tx_data", tx_data, exp_b);
            m_last_data = exp_b;
          end
        end else begin
          chk("tx_data_hold", tx_data, m_last_data);
        end
      end
    end

    if (!rst_n) begin
      m_init = 1; m_rst_prev = 1; m_pend[0] = 0; m_pend[1] = 0; m_ovf = '0;
      m_last = 1; m_cur = -1; m_sent = 0; m_hs = 0; m_last_data = '0;
      m_exp_pulse = 0; m_exp_sbusy = 0;
    end else if (m_init) begin
      m_rst_prev = 0;
      nxt = 0;
      hs0 = m_hs;
      if (tx_vld && m_cur >= 0) begin
        fin = (m_cur == 1) || (m_sent == 1);
        if (fin) begin m_pend[m_cur] = 0; m_cur = -1; end
        else m_sent = 1;
        m_hs = 1;
      end else if (m_hs == 1 && tx_busy) begin
        m_hs = 2;
      end else if (m_hs == 2 && !tx_busy) begin
        m_hs = 0;
        if (m_cur == 0) nxt = 1;
      end
      // arbitration decision is made from what is pending in this cycle
      if (hs0 == 0 && !tx_vld && !tx_busy && m_cur < 0 && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0] && m_pend[1]) sel = 1 - m_last;
        else sel = m_pend[0] ? 0 : 1;
        m_cur = sel; m_last = sel; m_sent = 0; nxt = 1;
      end
      if (alu_vld) begin
        if (m_pend[0]) m_ovf[0] = 1'b1;
        else begin m_pend[0] = 1; m_word[0] = alu_out; end
      end
      if (rd_vld) begin
        if (m_pend[1]) m_ovf[1] = 1'b1;
        else begin m_pend[1] = 1; m_word[1] = {8'h00, rd}; end
      end
      m_exp_pulse = nxt;
      m_exp_sbusy = m_pend[0] || m_pend[1] || (m_hs != 0) || (m_cur >= 0);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(bit a, logic [15:0] av, bit r, logic [7:0] rv);
    alu_vld = a; alu_out = av; rd_vld = r; rd = rv;
    tick();
    alu_vld = 0; rd_vld = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; tick(2); rst_n = 1;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((sbusy || tx_busy) && n < 400) begin tick(); n++; end
    chk({nm, "_drain_timeout"}, (n < 400), 1);
  endtask

  task automatic wait_pulses(string nm, int k);
    int n = 0;
    while (log_q.size() < k && n < 100) begin tick(); n++; end
    chk({nm, "_pulse_timeout"}, (n < 100), 1);
  endtask

  task automatic chk_log(string nm, logic [7:0] e[$]);
    chk({nm, "_count"}, log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), log_q[i], e[i]);
    log_q.delete();
  endtask

  initial begin
    logic [7:0] e[$];
    int s;
    tick(3);
    rst_n = 1;
    tick(2);

    // 1: single RdData byte, 2-cycle latency
    log_q.delete(); first_pulse_cyc = -1;
    s = cyc + 1;
    send(0, '0, 1, 8'h55);
    wait_idle("t1");
    chk("t1_latency", first_pulse_cyc - s, 2);
    chk("t1_sched_busy_low", sbusy, 0);
    e = '{8'h55}; chk_log("t1", e);

    // 2: ALU word split into two bytes
    send(1, 16'hA5C3, 0, '0);
    wait_idle("t2");
    if (MSB) e = '{8'hA5, 8'hC3}; else e = '{8'hC3, 8'hA5};
    chk_log("t2", e);

    // 3: simultaneous strobes from reset, ALU wins the tie
    do_reset(); log_q.delete();
    send(1, 16'h1234, 1, 8'h77);
    wait_idle("t3");
    if (MSB) e = '{8'h12, 8'h34, 8'h77}; else e = '{8'h34, 8'h12, 8'h77};
    chk_log("t3", e);

    // 4: new words arrive while a RdData byte is in flight
    send(0, '0, 1, 8'h01);
    wait_pulses("t4", 1);
    send(1, 16'h0203, 1, 8'h04);
    wait_idle("t4");
    if (MSB) e = '{8'h01, 8'h02, 8'h03, 8'h04}; else e = '{8'h01, 8'h03, 8'h02, 8'h04};
    chk_log("t4", e);

    // 5: second ALU word dropped while the first is pending
    send(1, 16'hA5C3, 0, '0);
    send(1, 16'hFFFF, 0, '0);
    wait_idle("t5");
    chk("t5_overflow", ovf, 2'b01);
    if (MSB) e = '{8'hA5, 8'hC3}; else e = '{8'hC3, 8'hA5};
    chk_log("t5", e);

    // 6: reset while waiting on the first ALU byte's frame
    send(1, 16'hA5C3, 0, '0);
    wait_pulses("t6", 1);
    tick(3);
    rst_n = 0; tick(); rst_n = 1;
    chk("t6_overflow_cleared", ovf, 0);
    wait_idle("t6");
    if (MSB) e = '{8'hA5}; else e = '{8'hC3};
    chk_log("t6", e);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      alu_vld = ($urandom_range(0, 9) == 0);
      alu_out = 16'($urandom);
      rd_vld  = ($urandom_range(0, 9) == 0);
      rd      = 8'($urandom);
      if ($urandom_range(0, 999) == 0) rst_n = 0; else rst_n = 1;
      tick();
    end
    alu_vld = 0; rd_vld = 0; rst_n = 1;
    tick();
    wait_idle("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Transmit scheduler that shares the UART transmitter between two requesters: the ALU result path (2*WIDTH bits) and the register-file read path (WIDTH bits). It buffers one word per requester and arbitrates round-robin between them. Wide words are split into bytes, and each byte is handed to the UART transmitter using its Data_valid/Busy handshake. It sits between the system controller datapath and the UART transmitter, and drives the transmitter's Data and Data_valid inputs.

Parameters:
WIDTH, 8, UART frame data width; the ALU word is 2*WIDTH.

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
ALU_Out  in  2*WIDTH  ALU result word
ALU_Valid  in  1  one-cycle strobe, ALU_Out valid
RdData  in  WIDTH  register-file read data
RdData_Valid  in  1  one-cycle strobe, RdData valid
Tx_Busy  in  1  UART transmitter busy (frame in progress)
Tx_Data  out  WIDTH  byte to UART transmitter, registered
Tx_Data_Valid  out  1  one-cycle strobe to UART transmitter, registered
Sched_Busy  out  1  high when any word is pending or FSM is not IDLE
Overflow  out  2  sticky drop flags: [0] ALU, [1] RdData

Behaviour:
- Reset (Reset==0 at a rising edge), next-edge values:
  - Tx_Data=0, Tx_Data_Valid=0, Sched_Busy=0, Overflow=2'b00.
  - Both pending flags cleared; FSM=IDLE; last_grant=RdData, so ALU wins the first tie.
  - An in-flight UART frame is not aborted; the transmitter has its own reset.
- Capture, per requester:
  - Valid with pending==0: latch data into the holding register; pending=1 next cycle.
  - Valid with pending==1: input dropped, holding register unchanged, matching Overflow bit set. Overflow clears only on reset.
  - Pending clears in the cycle the requester's last byte is issued (Tx_Data_Valid high). A valid in that same cycle is accepted: new data latched, pending stays 1.
- Arbitration (IDLE only):
  - One pending: grant it.
  - Both pending: grant the requester not in last_grant; update last_grant on every grant.
  - Simultaneous valids: both captured, arbitration as above.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
  - IDLE -> ISSUE: any pending and Tx_Busy==0. Byte index set to 0.
  - ISSUE: Tx_Data_Valid=1 for exactly one cycle; Tx_Data = selected byte. -> WAIT_HI.
  - WAIT_HI -> WAIT_LO: Tx_Busy==1. No timeout; a stuck-low Tx_Busy hangs the FSM (documented limitation).
  - WAIT_LO: wait for Tx_Busy==0. If the grant is ALU and byte index is 0: index=1, -> ISSUE. Otherwise -> IDLE.
- Byte order: ALU sends ALU_Out[WIDTH-1:0] first, then [2*WIDTH-1:WIDTH]. RdData is a single byte.
- Tx_Data holds its value between ISSUE cycles.
- Tx_Data_Valid is never asserted while Tx_Busy==1.
- Latency: from an idle scheduler with Tx_Busy==0, Tx_Data_Valid rises 2 cycles after the source valid strobe.
- Holding registers are not modified while their word is being serviced; only capture after pending clears changes them.

Optional Feature:
UART_TX_SCHED_MSB_FIRST_EN
- Defined: the ALU word is sent high byte first, then low byte.
- Undefined: low byte first (default).
- Arbitration, handshake and timing are identical in both cases.

Test Plan:
1. UART transmitter model with Busy for 11 cycles. RdData=8'h55 strobe -> Tx_Data_Valid one-cycle pulse 2 cycles later, Tx_Data=8'h55, Sched_Busy low after Busy falls.
2. ALU_Out=16'hA5C3 strobe -> first pulse Tx_Data=8'hC3; second pulse Tx_Data=8'hA5 only after Tx_Busy falls; exactly 2 pulses total.
3. Same-cycle ALU_Out=16'h1234 and RdData=8'h77 -> order 8'h34, 8'h12, 8'h77.
4. RdData=8'h01 strobe, then ALU_Out=16'h0203 and RdData=8'h04 while 8'h01 is in flight -> order 01, 03, 02, 04.
5. Second ALU_Valid (16'hFFFF) while ALU word 16'hA5C3 pending -> bytes C3, A5 only; Overflow=2'b01 until reset.
6. Reset low during WAIT_LO of the ALU low byte -> next edge: Tx_Data_Valid=0, Tx_Data=0, Overflow=0, Sched_Busy=0; no high byte sent after release.
7. With UART_TX_SCHED_MSB_FIRST_EN defined, ALU_Out=16'hA5C3 -> 8'hA5 then 8'hC3.
